bitmap_decoder: RTL and testbench
=================================

Name: bitmap_decoder

Overview:
- Inverse of the 256-bit priority encoder: turns 8-bit indices back into one-hot positions and maintains a registered 256-bit occupancy bitmap.
- Upstream logic sets and clears entries by index.
- The bitmap feeds the priority encoder, which selects the highest set entry.
- Also provides a registered one-hot decode output, a population count and full/empty flags.

Parameters:
- W, 256, bitmap width; must be a power of two, at least 8.
- IDXW, $clog2(W) = 8, index width.
- CNTW, IDXW+1 = 9, population count width (must represent W).

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- dec_valid  in  1  decode request strobe.
- dec_idx  in  IDXW  index to decode.
- set_valid  in  1  set-bit request.
- set_idx  in  IDXW  index of bit to set.
- clr_valid  in  1  clear-bit request.
- clr_idx  in  IDXW  index of bit to clear.
- onehot  out  W  registered one-hot of dec_idx.
- onehot_valid  out  1  onehot holds a fresh result.
- bitmap  out  W  registered occupancy vector; goes to the priority encoder.
- count  out  CNTW  number of set bits in bitmap.
- empty  out  1  count == 0.
- full  out  1  count == W.

Behaviour:
- Reset (rst=1 at a clock edge): onehot=0, onehot_valid=0, bitmap=0, count=0, empty=1, full=0. Reset wins over every request in the same cycle. Mid-operation reset discards all pending requests.
- Decode path, latency 1 cycle:
  - dec_valid=1 at edge N: onehot = (1 << dec_idx) and onehot_valid=1 after edge N.
  - dec_valid=0: onehot_valid=0 and onehot holds its last value.
  - Exactly one bit of onehot is set whenever onehot_valid=1.
  - Back-to-back requests every cycle are supported; there is no backpressure.
- Bitmap update, applied at each edge:
  - set_valid only: bitmap[set_idx] <= 1.
  - clr_valid only: bitmap[clr_idx] <= 0.
  - Both valid, different indices: both applied in the same cycle.
  - Both valid, same index: set wins and the bit ends 1.
  - Setting an already-set bit or clearing an already-clear bit is legal and leaves the bit unchanged.
- Count update, registered with bitmap so it is consistent with bitmap on the same cycle:
  - count_next = count + inc - dec.
  - inc = set_valid and the bit was 0.
  - dec = clr_valid and the bit was 1 and the clear is not overridden by a same-index set.
  - Net change per cycle is one of -1, 0, +1. The result never wraps; this is guaranteed by the rules above, not by saturation logic.
- Flags:
  - empty and full are registered and derived from count_next, so they change on the same cycle as count.
  - full=1 only when all W bits are set.
  - A set while full is a no-op. A clear while empty is a no-op.
- The decode path and the bitmap path are independent; dec_idx may equal set_idx/clr_idx with no interaction.
- No X propagation: all outputs are driven from flops after the first reset.

Decomposition:
- Shared package bitmap_pkg holds:
  - W, IDXW, CNTW;
  - the typedef bitmap_t = logic[W-1:0];
  - the typedef idx_t = logic[IDXW-1:0].
- The priority encoder and this block both import bitmap_pkg.
- One combinational sub-module, onehot_decoder (idx_t in, bitmap_t out):
  - built hierarchically from 3-to-8 decode stages gated by upper-index enables, mirroring the encoder's 8/32/128 grouping;
  - instantiated three times: decode, set mask, clear mask.
- The count, flag and bitmap registers stay in bitmap_decoder.

Test Plan:
- Reset: assert rst for 2 cycles with set_valid=1, set_idx=5 -> bitmap=0, count=0, empty=1, full=0, onehot_valid=0.
- Decode sweep: dec_valid=1, dec_idx=0,1,7,8,127,128,255 on consecutive cycles -> one cycle later onehot = 1<<idx each cycle, onehot_valid=1, popcount(onehot)=1. Then dec_valid=0 -> onehot_valid=0 and onehot holds 1<<255.
- Set/clear basic: set 3, set 200, set 3 again -> bitmap bits {3,200} set, count=2. Then clr 3 -> count=1. Then clr 3 again -> count=1 unchanged. Priority encoder on bitmap returns 200.
- Simultaneous requests:
  - set_idx=10 and clr_idx=10 in one cycle on a clear bit -> bit10=1, count+1.
  - The same on a set bit -> bit10=1, count unchanged.
  - set_idx=20 and clr_idx=10 with bit10 set -> bit20=1, bit10=0, count unchanged.
- Fill/drain: set indices 0..255 over 256 cycles -> full=1 exactly after the 256th edge, count=256. An extra set 0 -> count stays 256. Then clear 255..0 -> empty=1 after the last, count=0. An extra clear -> no change.
- Reset mid-operation: with count=100, assert rst for 1 cycle while set_valid and dec_valid are active -> next cycle bitmap=0, count=0, onehot_valid=0. Requests resume normally the following cycle.

Source files
------------

// File: rtl/bitmap_pkg.sv
// bitmap_pkg: shared sizing and types for the occupancy bitmap and the
// priority encoder that consumes it.
//   W    - bitmap width (power of two, >= 8)
//   IDXW - index width
//   CNTW - population count width, wide enough to hold W
package bitmap_pkg;
    localparam int W    = 256;
    localparam int IDXW = $clog2(W);
    localparam int CNTW = IDXW + 1;

    typedef logic [W-1:0]    bitmap_t;
    typedef logic [IDXW-1:0] idx_t;
    typedef logic [CNTW-1:0] cnt_t;
endpackage

// File: rtl/bitmap_decoder_onehot.sv
// onehot_decoder: combinational index -> one-hot decode.
//   idx    in  IDXW  index to decode
//   onehot out W     (1 << idx)
// Built as a 3-to-8 decode of idx[2:0] replicated across W/8 groups, each
// group gated by an enable decoded from the upper index bits. This mirrors
// the 8-bit grouping used by the priority encoder.
module onehot_decoder
    import bitmap_pkg::*;
(
    input  idx_t    idx,
    output bitmap_t onehot
);
    localparam int NGRP = W / 8;

    logic [7:0]      lo;
    logic [NGRP-1:0] grp_en;

    assign lo = 8'(1) << idx[2:0];

    generate
        if (NGRP > 1) begin : g_hi
            assign grp_en = NGRP'(1) << idx[IDXW-1:3];
        end else begin : g_one
            assign grp_en = 1'b1;
        end

        for (genvar g = 0; g < NGRP; g++) begin : g_grp
            assign onehot[g*8 +: 8] = grp_en[g] ? lo : 8'h00;
        end
    endgenerate
endmodule

// File: rtl/bitmap_decoder.sv
// bitmap_decoder: registered one-hot decode plus a set/clear occupancy
// bitmap with population count and full/empty flags.
//   clk, rst         clock, synchronous active-high reset
//   dec_valid/idx    decode request; onehot/onehot_valid one cycle later
//   set_valid/idx    set a bitmap entry
//   clr_valid/idx    clear a bitmap entry (a same-index set wins)
//   bitmap           registered occupancy vector
//   count            number of set bits, registered with bitmap
//   empty, full      registered from the next count
module bitmap_decoder
    import bitmap_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            dec_valid,
    input  logic [IDXW-1:0] dec_idx,
    input  logic            set_valid,
    input  logic [IDXW-1:0] set_idx,
    input  logic            clr_valid,
    input  logic [IDXW-1:0] clr_idx,
    output logic [W-1:0]    onehot,
    output logic            onehot_valid,
    output logic [W-1:0]    bitmap,
    output logic [CNTW-1:0] count,
    output logic            empty,
    output logic            full
);
    bitmap_t dec_mask, set_mask, clr_mask, bitmap_next;
    logic    inc, dec;
    cnt_t    count_next;

    onehot_decoder u_dec (.idx(dec_idx), .onehot(dec_mask));
    onehot_decoder u_set (.idx(set_idx), .onehot(set_mask));
    onehot_decoder u_clr (.idx(clr_idx), .onehot(clr_mask));

    // Count tracks actual bit transitions, so redundant set/clear requests
    // and the set-over-clear collision never move it; that alone keeps
    // count inside [0, W] with no saturation logic.
    always_comb begin
        inc = set_valid && ((bitmap & set_mask) == '0);
        dec = clr_valid && ((bitmap & clr_mask) != '0)
              && !(set_valid && (set_idx == clr_idx));
        // Clear first, then OR in the set so a same-index set wins.
        bitmap_next = (bitmap & ~(clr_valid ? clr_mask : '0))
                      | (set_valid ? set_mask : '0);
        count_next  = count + cnt_t'(inc) - cnt_t'(dec);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            onehot       <= '0;
            onehot_valid <= 1'b0;
            bitmap       <= '0;
            count        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
        end else begin
            onehot_valid <= dec_valid;
            if (dec_valid)
                onehot <= dec_mask;
            bitmap <= bitmap_next;
            count  <= count_next;
            empty  <= (count_next == '0);
            full   <= (count_next == cnt_t'(W));
        end
    end
endmodule

// File: tb/tb_bitmap_decoder.sv
module tb_bitmap_decoder;
    localparam int W    = 256;
    localparam int IDXW = 8;
    localparam int CNTW = 9;

    logic            clk = 1'b0;
    logic            rst;
    logic            dec_valid, set_valid, clr_valid;
    logic [IDXW-1:0] dec_idx, set_idx, clr_idx;
    logic [W-1:0]    onehot, bitmap;
    logic            onehot_valid, empty, full;
    logic [CNTW-1:0] count;

    int nvec = 0;
    int nerr = 0;

    bitmap_decoder dut (
        .clk(clk), .rst(rst),
        .dec_valid(dec_valid), .dec_idx(dec_idx),
        .set_valid(set_valid), .set_idx(set_idx),
        .clr_valid(clr_valid), .clr_idx(clr_idx),
        .onehot(onehot), .onehot_valid(onehot_valid),
        .bitmap(bitmap), .count(count), .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] bit_at(input int i);
        logic [W-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Reference priority encoder: highest set index, or -1 when empty.
    function automatic int prio(input logic [W-1:0] v);
        for (int i = W - 1; i >= 0; i--)
            if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [W-1:0] cnt(input int n);
        return W'(n);
    endfunction

    int dec_list [7] = '{0, 1, 7, 8, 127, 128, 255};
    logic [W-1:0] exp_bm;

    initial begin
        rst = 1'b1; dec_valid = 0; dec_idx = 0;
        set_valid = 1; set_idx = 8'd5; clr_valid = 0; clr_idx = 0;

        // Reset wins over a concurrent set.
        tick(); tick();
        rst = 1'b0; set_valid = 0;
        chk("rst_bitmap", bitmap, '0);
        chk("rst_count", cnt(count), cnt(0));
        chk("rst_empty", W'(empty), W'(1));
        chk("rst_full", W'(full), W'(0));
        chk("rst_ohv", W'(onehot_valid), W'(0));
        chk("rst_onehot", onehot, '0);

        // Decode sweep, one request per cycle.
        foreach (dec_list[k]) begin
            dec_valid = 1; dec_idx = IDXW'(dec_list[k]);
            tick();
            chk($sformatf("dec_oh_%0d", dec_list[k]), onehot, bit_at(dec_list[k]));
            chk($sformatf("dec_v_%0d", dec_list[k]), W'(onehot_valid), W'(1));
            chk($sformatf("dec_pc_%0d", dec_list[k]), W'($countones(onehot)), W'(1));
        end
        dec_valid = 0;
        tick();
        chk("dec_idle_v", W'(onehot_valid), W'(0));
        chk("dec_idle_hold", onehot, bit_at(255));

        // Basic set/clear.
        set_valid = 1; set_idx = 3;   tick();
        set_idx = 200;                tick();
        set_idx = 3;                  tick();
        set_valid = 0;
        chk("sc_bitmap", bitmap, bit_at(3) | bit_at(200));
        chk("sc_count2", cnt(count), cnt(2));
        clr_valid = 1; clr_idx = 3;   tick();
        chk("sc_clr_count", cnt(count), cnt(1));
        tick();
        clr_valid = 0;
        chk("sc_clr2_count", cnt(count), cnt(1));
        chk("sc_clr_bitmap", bitmap, bit_at(200));
        chk("sc_prio", W'(prio(bitmap)), W'(200));

        // Simultaneous set/clear.
        set_valid = 1; set_idx = 10; clr_valid = 1; clr_idx = 10;
        tick();
        chk("sim_same_clrbit_bm", bitmap, bit_at(10) | bit_at(200));
        chk("sim_same_clrbit_cnt", cnt(count), cnt(2));
        tick();
        chk("sim_same_setbit_bm", bitmap, bit_at(10) | bit_at(200));
        chk("sim_same_setbit_cnt", cnt(count), cnt(2));
        set_idx = 20;
        tick();
        set_valid = 0; clr_valid = 0;
        chk("sim_diff_bm", bitmap, bit_at(20) | bit_at(200));
        chk("sim_diff_cnt", cnt(count), cnt(2));

        // Drain to empty before the fill test.
        clr_valid = 1; clr_idx = 20;  tick();
        clr_idx = 200;                tick();
        clr_valid = 0;
        chk("pre_empty", W'(empty), W'(1));
        chk("pre_count", cnt(count), cnt(0));

        // Fill 0..255.
        set_valid = 1;
        for (int i = 0; i < W; i++) begin
            set_idx = IDXW'(i);
            tick();
            if (i == 0)   chk("fill_not_empty", W'(empty), W'(0));
            if (i == 254) begin
                chk("fill_254_full", W'(full), W'(0));
                chk("fill_254_cnt", cnt(count), cnt(255));
            end
            if (i == 255) begin
                chk("fill_full", W'(full), W'(1));
                chk("fill_cnt", cnt(count), cnt(256));
                chk("fill_bm", bitmap, '1);
            end
        end
        set_idx = 0;
        tick();
        set_valid = 0;
        chk("full_extra_cnt", cnt(count), cnt(256));
        chk("full_extra_full", W'(full), W'(1));

        // Drain 255..0.
        clr_valid = 1;
        for (int i = W - 1; i >= 0; i--) begin
            clr_idx = IDXW'(i);
            tick();
            if (i == 255) chk("drain_not_full", W'(full), W'(0));
            if (i == 1) begin
                chk("drain_1_empty", W'(empty), W'(0));
                chk("drain_1_cnt", cnt(count), cnt(1));
            end
            if (i == 0) begin
                chk("drain_empty", W'(empty), W'(1));
                chk("drain_cnt", cnt(count), cnt(0));
            end
        end
        clr_idx = 0;
        tick();
        clr_valid = 0;
        chk("empty_extra_cnt", cnt(count), cnt(0));
        chk("empty_extra_empty", W'(empty), W'(1));
        chk("empty_extra_bm", bitmap, '0);

        // Reset mid-operation at count=100.
        set_valid = 1;
        exp_bm = '0;
        for (int i = 0; i < 100; i++) begin
            set_idx = IDXW'(i);
            exp_bm[i] = 1'b1;
            tick();
        end
        chk("mid_cnt100", cnt(count), cnt(100));
        chk("mid_bm100", bitmap, exp_bm);
        rst = 1; set_idx = 150; dec_valid = 1; dec_idx = 9;
        tick();
        rst = 0;
        chk("mid_rst_bm", bitmap, '0);
        chk("mid_rst_cnt", cnt(count), cnt(0));
        chk("mid_rst_ohv", W'(onehot_valid), W'(0));
        chk("mid_rst_empty", W'(empty), W'(1));
        set_idx = 7;
        tick();
        set_valid = 0; dec_valid = 0;
        chk("resume_bm", bitmap, bit_at(7));
        chk("resume_cnt", cnt(count), cnt(1));
        chk("resume_oh", onehot, bit_at(9));
        chk("resume_ohv", W'(onehot_valid), W'(1));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
